rf_write_arbiter: RTL and testbench
===================================

// Module: rf_write_arbiter
// PURPOSE
//  Sole owner of the RV32IM register file write port. Shares it between the in-order
//  pipeline writeback (WB) and the multi-cycle MUL/DIV unit (MD); MD results that lose
//  arbitration are buffered in a small FIFO. Keeps a pending-destination scoreboard for
//  issued MD ops and flags operand hazards to decode.
// PARAMETERS
//  DATA_W      32  register data width
//  ADDR_W      5   register address width (32 registers)
//  FIFO_DEPTH  2   MD result buffer entries (power of 2, >=2)
// PORTS
//  CLK              in   1       clock (all state on posedge)
//  RESET            in   1       one clock; reset is asynchronous and active-low
//  WB_VALID         in   1       pipeline writeback request
//  WB_ADDR          in   ADDR_W  WB destination
//  WB_DATA          in   DATA_W  WB data
//  MD_VALID         in   1       MD result valid
//  MD_READY         out  1       arbiter can accept MD result
//  MD_ADDR          in   ADDR_W  MD destination
//  MD_DATA          in   DATA_W  MD result
//  ISSUE_MD         in   1       MD op issued this cycle; reserve destination
//  ISSUE_ADDR       in   ADDR_W  destination of issued MD op
//  CHK_ADDR1/2      in   ADDR_W  decode-stage source operand addresses
//  BUSY1/2          out  1       operand 1/2 awaits an MD result
//  PENDING          out  32      scoreboard, bit n = register n reserved
//  RF_WRITE_ENABLE  out  1       to register file WRITE_ENABLE
//  RF_WRITE_ADDRESS out  ADDR_W  to register file WRITE_ADDRESS
//  RF_WRITE_DATA    out  DATA_W  to register file WRITE_DATA
//  PROTO_ERR        out  1       sticky protocol-violation flag
// BEHAVIOUR
//  Reset (RESET=0, async): RF_WRITE_* = 0, PENDING = 0, FIFO empty, PROTO_ERR = 0,
//   MD_READY = 0. Any buffered results or reservations are discarded; nothing written
//   after release. MD_READY rises on first posedge after release.
//  Request qualification: WB_VALID with WB_ADDR==0 is no request. MD handshake =
//   MD_VALID & MD_READY; MD_ADDR==0 result is accepted and dropped.
//  MD_READY = !fifo_full (registered state only; not dependent on WB_VALID).
//  Arbitration each cycle, fixed priority: (1) qualified WB, (2) FIFO head,
//   (3) MD bypass (only if FIFO empty and handshake fires). Winner registered onto
//   RF_WRITE_* at posedge: latency exactly 1 cycle. No winner -> RF_WRITE_ENABLE=0,
//   ADDRESS/DATA hold last value.
//  Accepted MD result that does not win is pushed to FIFO tail the same posedge; push
//   and pop in one cycle allowed (count unchanged). Pointers wrap mod FIFO_DEPTH.
//   Results leave FIFO strictly in acceptance order.
//  Scoreboard: ISSUE_MD sets PENDING[ISSUE_ADDR] (ignored for 0). Bit cleared on the
//   posedge an MD-sourced write for that address is driven onto RF_WRITE_*. Same-cycle
//   set and clear of one bit: set wins.
//  BUSY1 = PENDING[CHK_ADDR1], BUSY2 = PENDING[CHK_ADDR2]; combinational from
//   registered PENDING; address 0 always 0.
//  PROTO_ERR set (sticky to reset) on: ISSUE_MD to already-pending addr not cleared
//   that cycle; MD handshake with nonzero addr not pending; qualified WB to pending addr.
//   Offending op still processed as above.
//  Write-port timing: outputs change only at posedge; register file samples them
//   after its internal #1, so data is stable on its write.
// TESTING
//  T1 reset: RESET=0 mid-run, FIFO=2 entries -> RF_WRITE_ENABLE=0, PENDING=0,
//     MD_READY=0 immediately; after release no write of old entries, MD_READY=1.
//  T2 collision: ISSUE x7; then WB x5=0xAAAA5555 and MD x7=0x00001234 same cycle ->
//     cycle+1 writes x5, cycle+2 writes x7, PENDING[7] clears at cycle+2.
//  T3 backpressure: WB valid 5 cycles, MD offers 3 results x1..x3 -> 2 accepted,
//     MD_READY=0 holds third; after WB stops writes x1,x2,x3 in order on consecutive cycles.
//  T4 scoreboard: ISSUE x10, CHK_ADDR1=10 -> BUSY1=1 next cycle; MD x10 written -> BUSY1=0
//     same posedge; CHK_ADDR2=0 -> BUSY2=0 always.
//  T5 x0: WB_ADDR=0 with FIFO head x4 -> x4 written that cycle; ISSUE x0 -> PENDING=0.
//  T6 errors: ISSUE x3 twice, or MD x9 unreserved -> PROTO_ERR=1, stays until RESET=0.

Source files
------------

// File: rtl/rf_write_arbiter_if.sv
// Register-file write arbiter bus bundle.
// Groups the pipeline writeback request, MUL/DIV result handshake, MD issue
// reservation, decode hazard query and the register-file write port.
//   master : pipeline / MD unit / decode side (drives requests, reads status)
//   slave  : the arbiter (reads requests, drives write port and status)
interface rf_write_arbiter_if #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 5
);
   localparam int unsigned NREG = 1 << ADDR_W;

   logic              WB_VALID;
   logic [ADDR_W-1:0] WB_ADDR;
   logic [DATA_W-1:0] WB_DATA;
   logic              MD_VALID;
   logic              MD_READY;
   logic [ADDR_W-1:0] MD_ADDR;
   logic [DATA_W-1:0] MD_DATA;
   logic              ISSUE_MD;
   logic [ADDR_W-1:0] ISSUE_ADDR;
   logic [ADDR_W-1:0] CHK_ADDR1;
   logic [ADDR_W-1:0] CHK_ADDR2;
   logic              BUSY1;
   logic              BUSY2;
   logic [NREG-1:0]   PENDING;
   logic              RF_WRITE_ENABLE;
   logic [ADDR_W-1:0] RF_WRITE_ADDRESS;
   logic [DATA_W-1:0] RF_WRITE_DATA;
   logic              PROTO_ERR;

   modport master (
      output WB_VALID, WB_ADDR, WB_DATA,
      output MD_VALID, MD_ADDR, MD_DATA,
      output ISSUE_MD, ISSUE_ADDR, CHK_ADDR1, CHK_ADDR2,
      input  MD_READY, BUSY1, BUSY2, PENDING,
      input  RF_WRITE_ENABLE, RF_WRITE_ADDRESS, RF_WRITE_DATA, PROTO_ERR
   );

   modport slave (
      input  WB_VALID, WB_ADDR, WB_DATA,
      input  MD_VALID, MD_ADDR, MD_DATA,
      input  ISSUE_MD, ISSUE_ADDR, CHK_ADDR1, CHK_ADDR2,
      output MD_READY, BUSY1, BUSY2, PENDING,
      output RF_WRITE_ENABLE, RF_WRITE_ADDRESS, RF_WRITE_DATA, PROTO_ERR
   );
endinterface

// File: rtl/rf_write_arbiter.sv
// Sole owner of the RV32IM register-file write port.
// Fixed priority each cycle: qualified WB, then MD FIFO head, then MD bypass
// (FIFO empty only). Winner is registered onto RF_WRITE_* (1-cycle latency).
// MD results that lose are buffered in order; a pending-destination
// scoreboard drives operand hazard flags and a sticky protocol error.
// Ports:
//   CLK   : clock, all state on posedge
//   RESET : asynchronous active-low reset
//   bus   : rf_write_arbiter_if.slave (WB, MD handshake, issue, hazard query,
//           register-file write port, PROTO_ERR)
module rf_write_arbiter #(
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned ADDR_W     = 5,
   parameter int unsigned FIFO_DEPTH = 2
) (
   input logic               CLK,
   input logic               RESET,
   rf_write_arbiter_if.slave bus
);
   localparam int unsigned NREG  = 1 << ADDR_W;
   localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CNT_W = PTR_W + 1;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } md_entry_t;

   md_entry_t         fifo_mem [FIFO_DEPTH];
   md_entry_t         head;
   logic [PTR_W-1:0]  rd_ptr_q, wr_ptr_q;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              md_ready_q;
   logic [NREG-1:0]   pending_q, pending_d;
   logic              err_q, err_d;
   logic              wr_en_q, wr_en_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic [DATA_W-1:0] wr_data_q, wr_data_d;

   logic              wb_req, md_hs, md_acc, fifo_empty, issue_v;
   logic              push, pop, bypass, md_win;
   logic [NREG-1:0]   set_mask, clr_mask;

   assign head       = fifo_mem[rd_ptr_q];
   assign fifo_empty = (count_q == '0);
   assign wb_req     = bus.WB_VALID & (bus.WB_ADDR != '0);
   assign md_hs      = bus.MD_VALID & md_ready_q;
   // handshake to x0 is consumed but never written
   assign md_acc     = md_hs & (bus.MD_ADDR != '0);
   assign issue_v    = bus.ISSUE_MD & (bus.ISSUE_ADDR != '0);

   // Arbitration, FIFO bookkeeping, scoreboard and error next-state
   always_comb begin
      wr_en_d   = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      pop       = 1'b0;
      bypass    = 1'b0;
      md_win    = 1'b0;
      set_mask  = '0;
      clr_mask  = '0;

      if (wb_req) begin
         wr_en_d   = 1'b1;
         wr_addr_d = bus.WB_ADDR;
         wr_data_d = bus.WB_DATA;
      end else if (!fifo_empty) begin
         wr_en_d   = 1'b1;
         wr_addr_d = head.addr;
         wr_data_d = head.data;
         pop       = 1'b1;
         md_win    = 1'b1;
      end else if (md_acc) begin
         wr_en_d   = 1'b1;
         wr_addr_d = bus.MD_ADDR;
         wr_data_d = bus.MD_DATA;
         bypass    = 1'b1;
         md_win    = 1'b1;
      end

      push    = md_acc & ~bypass;
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);

      if (md_win)  clr_mask[wr_addr_d]      = 1'b1;
      if (issue_v) set_mask[bus.ISSUE_ADDR] = 1'b1;
      // a same-cycle reissue of the retiring register keeps it reserved
      pending_d = (pending_q & ~clr_mask) | set_mask;

      err_d = err_q
            | (issue_v & pending_q[bus.ISSUE_ADDR] & ~clr_mask[bus.ISSUE_ADDR])
            | (md_acc & ~pending_q[bus.MD_ADDR])
            | (wb_req & pending_q[bus.WB_ADDR]);
   end

   // Control and write-port state
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
         md_ready_q <= 1'b0;
         pending_q  <= '0;
         err_q      <= 1'b0;
         wr_en_q    <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
      end else begin
         if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         count_q    <= count_d;
         md_ready_q <= (count_d != CNT_W'(FIFO_DEPTH));
         pending_q  <= pending_d;
         err_q      <= err_d;
         wr_en_q    <= wr_en_d;
         wr_addr_q  <= wr_addr_d;
         wr_data_q  <= wr_data_d;
      end
   end

   // Result storage; validity is tracked by the pointers/count only
   always_ff @(posedge CLK) begin
      if (push) fifo_mem[wr_ptr_q] <= md_entry_t'({bus.MD_ADDR, bus.MD_DATA});
   end

   assign bus.MD_READY         = md_ready_q;
   assign bus.PENDING          = pending_q;
   assign bus.PROTO_ERR        = err_q;
   assign bus.RF_WRITE_ENABLE  = wr_en_q;
   assign bus.RF_WRITE_ADDRESS = wr_addr_q;
   assign bus.RF_WRITE_DATA    = wr_data_q;
   assign bus.BUSY1            = (bus.CHK_ADDR1 != '0) & pending_q[bus.CHK_ADDR1];
   assign bus.BUSY2            = (bus.CHK_ADDR2 != '0) & pending_q[bus.CHK_ADDR2];
endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter: per-cycle vector table plus
// hand-written backpressure, reset and protocol-error sequences.
module tb_rf_write_arbiter;
   logic CLK = 1'b0;
   logic RESET = 1'b0;
   int   checks = 0;
   int   errors = 0;

   always #5 CLK = ~CLK;

   rf_write_arbiter_if bif ();

   rf_write_arbiter dut (
      .CLK   (CLK),
      .RESET (RESET),
      .bus   (bif)
   );

   typedef struct {
      logic        wb_v;  logic [4:0] wb_a;  logic [31:0] wb_d;
      logic        md_v;  logic [4:0] md_a;  logic [31:0] md_d;
      logic        iss;   logic [4:0] iss_a;
      logic [4:0]  chk1;  logic [4:0] chk2;
      logic        e_we;  logic [4:0] e_wa;  logic [31:0] e_wd;
      logic        e_rdy; logic       e_b1;  logic        e_b2;
      logic [31:0] e_pend; logic      e_err;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic idle();
      bif.WB_VALID = 0; bif.WB_ADDR = 0; bif.WB_DATA = 0;
      bif.MD_VALID = 0; bif.MD_ADDR = 0; bif.MD_DATA = 0;
      bif.ISSUE_MD = 0; bif.ISSUE_ADDR = 0;
      bif.CHK_ADDR1 = 0; bif.CHK_ADDR2 = 0;
   endtask

   task automatic add(input logic wb_v, input logic [4:0] wb_a, input logic [31:0] wb_d,
                      input logic md_v, input logic [4:0] md_a, input logic [31:0] md_d,
                      input logic iss, input logic [4:0] iss_a,
                      input logic [4:0] chk1, input logic [4:0] chk2,
                      input logic e_we, input logic [4:0] e_wa, input logic [31:0] e_wd,
                      input logic e_rdy, input logic e_b1, input logic e_b2,
                      input logic [31:0] e_pend, input logic e_err);
      vec_t v;
      v.wb_v = wb_v; v.wb_a = wb_a; v.wb_d = wb_d;
      v.md_v = md_v; v.md_a = md_a; v.md_d = md_d;
      v.iss = iss; v.iss_a = iss_a; v.chk1 = chk1; v.chk2 = chk2;
      v.e_we = e_we; v.e_wa = e_wa; v.e_wd = e_wd; v.e_rdy = e_rdy;
      v.e_b1 = e_b1; v.e_b2 = e_b2; v.e_pend = e_pend; v.e_err = e_err;
      vecs.push_back(v);
   endtask

   task automatic issue(input logic [4:0] a);
      idle();
      bif.ISSUE_MD = 1; bif.ISSUE_ADDR = a;
      tick();
   endtask

   task automatic do_reset();
      idle();
      #2 RESET = 0;
      tick();
      #2 RESET = 1;
      tick();
   endtask

   initial begin
      logic [31:0] exp_wa [8];
      logic        exp_rdy[8];
      int          k;
      logic        hs;

      // reset state
      idle();
      tick(); tick();
      chk("rst_we", 32'(bif.RF_WRITE_ENABLE), 0);
      chk("rst_pend", bif.PENDING, 0);
      chk("rst_rdy", 32'(bif.MD_READY), 0);
      chk("rst_err", 32'(bif.PROTO_ERR), 0);
      #2 RESET = 1;
      tick();
      chk("rel_rdy", 32'(bif.MD_READY), 1);
      chk("rel_we", 32'(bif.RF_WRITE_ENABLE), 0);

      //   wb          md                 issue  chk     | we wa wd           rdy b1 b2 pend     err
      add(0,0,0,           0,0,0,           1,7,  7,0,   0,0,0,            1,1,0,32'h80,0);
      add(1,5,32'hAAAA5555,1,7,32'h1234,    0,0,  7,0,   1,5,32'hAAAA5555, 1,1,0,32'h80,0);
      add(0,0,0,           0,0,0,           0,0,  7,0,   1,7,32'h1234,     1,0,0,0,0);
      add(0,0,0,           0,0,0,           0,0,  7,0,   0,7,32'h1234,     1,0,0,0,0);
      add(0,0,0,           0,0,0,           1,10, 10,0,  0,7,32'h1234,     1,1,0,32'h400,0);
      add(0,0,0,           1,10,32'hCAFE0010,0,0, 10,0,  1,10,32'hCAFE0010,1,0,0,0,0);
      add(0,0,0,           0,0,0,           1,4,  4,0,   0,10,32'hCAFE0010,1,1,0,32'h10,0);
      add(1,6,32'h66,      1,4,32'h44444444,0,0,  4,6,   1,6,32'h66,       1,1,0,32'h10,0);
      add(1,0,32'hDEAD,    0,0,0,           1,0,  4,0,   1,4,32'h44444444, 1,0,0,0,0);
      add(0,0,0,           1,0,32'h99,      0,0,  0,0,   0,4,32'h44444444, 1,0,0,0,0);
      add(0,0,0,           0,0,0,           1,12, 12,12, 0,4,32'h44444444, 1,1,1,32'h1000,0);
      add(0,0,0,           1,12,32'h12121212,1,12,12,0,  1,12,32'h12121212,1,1,0,32'h1000,0);
      add(0,0,0,           1,12,32'h2,      0,0,  12,0,  1,12,32'h2,       1,0,0,0,0);

      foreach (vecs[i]) begin
         bif.WB_VALID = vecs[i].wb_v; bif.WB_ADDR = vecs[i].wb_a; bif.WB_DATA = vecs[i].wb_d;
         bif.MD_VALID = vecs[i].md_v; bif.MD_ADDR = vecs[i].md_a; bif.MD_DATA = vecs[i].md_d;
         bif.ISSUE_MD = vecs[i].iss; bif.ISSUE_ADDR = vecs[i].iss_a;
         bif.CHK_ADDR1 = vecs[i].chk1; bif.CHK_ADDR2 = vecs[i].chk2;
         tick();
         chk($sformatf("v%0d_we", i), 32'(bif.RF_WRITE_ENABLE), 32'(vecs[i].e_we));
         chk($sformatf("v%0d_wa", i), 32'(bif.RF_WRITE_ADDRESS), 32'(vecs[i].e_wa));
         chk($sformatf("v%0d_wd", i), bif.RF_WRITE_DATA, vecs[i].e_wd);
         chk($sformatf("v%0d_rdy", i), 32'(bif.MD_READY), 32'(vecs[i].e_rdy));
         chk($sformatf("v%0d_b1", i), 32'(bif.BUSY1), 32'(vecs[i].e_b1));
         chk($sformatf("v%0d_b2", i), 32'(bif.BUSY2), 32'(vecs[i].e_b2));
         chk($sformatf("v%0d_pend", i), bif.PENDING, vecs[i].e_pend);
         chk($sformatf("v%0d_err", i), 32'(bif.PROTO_ERR), 32'(vecs[i].e_err));
      end

      // backpressure: WB busy 5 cycles while MD offers x1..x3
      issue(1); issue(2); issue(3);
      chk("bp_pend", bif.PENDING, 32'h0000000E);
      exp_rdy = '{1, 1, 0, 0, 0, 0, 1, 1};
      exp_wa  = '{20, 21, 22, 23, 24, 1, 2, 3};
      k = 0;
      for (int c = 0; c < 8; c++) begin
         idle();
         bif.WB_VALID = (c < 5); bif.WB_ADDR = 5'(20 + c); bif.WB_DATA = 32'h100 + 32'(c);
         bif.MD_VALID = (k < 3); bif.MD_ADDR = 5'(k + 1); bif.MD_DATA = 32'h1000 + 32'(k + 1);
         #1;
         chk($sformatf("bp%0d_rdy", c), 32'(bif.MD_READY), 32'(exp_rdy[c]));
         hs = bif.MD_VALID & bif.MD_READY;
         tick();
         if (hs) k++;
         chk($sformatf("bp%0d_we", c), 32'(bif.RF_WRITE_ENABLE), 1);
         chk($sformatf("bp%0d_wa", c), 32'(bif.RF_WRITE_ADDRESS), exp_wa[c]);
         chk($sformatf("bp%0d_wd", c), bif.RF_WRITE_DATA,
             (c < 5) ? 32'h100 + 32'(c) : 32'h1000 + exp_wa[c]);
      end
      chk("bp_pend_end", bif.PENDING, 0);
      chk("bp_err", 32'(bif.PROTO_ERR), 0);

      // mid-run reset with two buffered results
      idle(); tick();
      issue(8); issue(9);
      idle();
      bif.WB_VALID = 1; bif.WB_ADDR = 21; bif.WB_DATA = 32'h21;
      bif.MD_VALID = 1; bif.MD_ADDR = 8;  bif.MD_DATA = 32'h88;
      tick();
      bif.WB_ADDR = 22; bif.WB_DATA = 32'h22;
      bif.MD_ADDR = 9;  bif.MD_DATA = 32'h99;
      tick();
      chk("mr_rdy_full", 32'(bif.MD_READY), 0);
      idle();
      #2 RESET = 0;
      #1;
      chk("mr_we", 32'(bif.RF_WRITE_ENABLE), 0);
      chk("mr_pend", bif.PENDING, 0);
      chk("mr_rdy", 32'(bif.MD_READY), 0);
      tick();
      #2 RESET = 1;
      tick();
      chk("mr_rel_rdy", 32'(bif.MD_READY), 1);
      chk("mr_rel_we0", 32'(bif.RF_WRITE_ENABLE), 0);
      tick();
      chk("mr_rel_we1", 32'(bif.RF_WRITE_ENABLE), 0);
      tick();
      chk("mr_rel_we2", 32'(bif.RF_WRITE_ENABLE), 0);

      // protocol errors: double issue, unreserved MD, WB to reserved reg
      issue(3);
      chk("pe_issue_once", 32'(bif.PROTO_ERR), 0);
      issue(3);
      chk("pe_issue_twice", 32'(bif.PROTO_ERR), 1);
      idle(); tick(); tick();
      chk("pe_sticky", 32'(bif.PROTO_ERR), 1);
      do_reset();
      chk("pe_rst_clr", 32'(bif.PROTO_ERR), 0);
      idle();
      bif.MD_VALID = 1; bif.MD_ADDR = 9; bif.MD_DATA = 32'h9;
      tick();
      chk("pe_md_unres", 32'(bif.PROTO_ERR), 1);
      chk("pe_md_wa", 32'(bif.RF_WRITE_ADDRESS), 9);
      do_reset();
      issue(5);
      idle();
      bif.WB_VALID = 1; bif.WB_ADDR = 5; bif.WB_DATA = 32'h55;
      tick();
      chk("pe_wb_res", 32'(bif.PROTO_ERR), 1);
      chk("pe_wb_wd", bif.RF_WRITE_DATA, 32'h55);
      idle(); tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
